// File: rtl/rtc_pkg.sv
// Shared RTC bus definitions: sequencer states, default bus timing
// and the RTC register map used by the PicoBlaze port decode.
package rtc_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_A_SET,
      S_A_STB,
      S_A_HLD,
      S_GAP,
      S_D_SET,
      S_D_STB,
      S_D_HLD,
      S_FIN
   } state_t;

   localparam int DEF_T_SETUP = 2;
   localparam int DEF_T_PULSE = 8;
   localparam int DEF_T_HOLD  = 2;
   localparam int DEF_T_GAP   = 4;
   localparam int DEF_CNT_W   = 4;

   localparam logic [7:0] RTC_SEC   = 8'h21;
   localparam logic [7:0] RTC_MIN   = 8'h22;
   localparam logic [7:0] RTC_HOUR  = 8'h23;
   localparam logic [7:0] RTC_DAY   = 8'h24;
   localparam logic [7:0] RTC_MONTH = 8'h25;
   localparam logic [7:0] RTC_YEAR  = 8'h26;

endpackage

// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed-bus sequencer: one address phase then one data phase,
// all strobes registered from the next state so they never glitch.
module rtc_bus_ctrl
   import rtc_pkg::*;
#(
   parameter int T_SETUP = DEF_T_SETUP,
   parameter int T_PULSE = DEF_T_PULSE,
   parameter int T_HOLD  = DEF_T_HOLD,
   parameter int T_GAP   = DEF_T_GAP,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rw,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       cs_n,
   output logic       ad,
   output logic       wr_n,
   output logic       rd_n,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   input  logic [7:0] bus_in
);

   state_t           r_state;
   state_t           w_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_load;
   logic             r_rw;
   logic [7:0]       r_addr;
   logic [7:0]       r_wdata;
   logic             r_busy;
   logic             r_done;
   logic [7:0]       r_rdata;
   logic             r_cs_n;
   logic             r_ad;
   logic             r_wr_n;
   logic             r_rd_n;
   logic [7:0]       r_bus_out;
   logic             r_bus_oe;
   logic             w_zero;
   logic             w_a_ph;
   logic             w_d_ph;
   logic [7:0]       w_addr;

   assign w_zero = (r_cnt == '0);
   assign w_a_ph = w_nxt inside {S_A_SET, S_A_STB, S_A_HLD};
   assign w_d_ph = w_nxt inside {S_D_SET, S_D_STB, S_D_HLD};
   // address must be driven in the very first A_SET clock
   assign w_addr = (r_state == S_IDLE) ? addr : r_addr;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_nxt = S_A_SET;
         S_A_SET: if (w_zero) w_nxt = S_A_STB;
         S_A_STB: if (w_zero) w_nxt = S_A_HLD;
         S_A_HLD: if (w_zero) w_nxt = S_GAP;
         S_GAP:   if (w_zero) w_nxt = S_D_SET;
         S_D_SET: if (w_zero) w_nxt = S_D_STB;
         S_D_STB: if (w_zero) w_nxt = S_D_HLD;
         S_D_HLD: if (w_zero) w_nxt = S_FIN;
         S_FIN:   w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_load = '0;
      case (w_nxt)
         S_A_SET, S_D_SET: w_load = CNT_W'(T_SETUP - 1);
         S_A_STB, S_D_STB: w_load = CNT_W'(T_PULSE - 1);
         S_A_HLD, S_D_HLD: w_load = CNT_W'(T_HOLD - 1);
         S_GAP:            w_load = CNT_W'(T_GAP - 1);
         default:          w_load = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_rw      <= 1'b0;
         r_addr    <= 8'h00;
         r_wdata   <= 8'h00;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rdata   <= 8'h00;
         r_cs_n    <= 1'b1;
         r_ad      <= 1'b0;
         r_wr_n    <= 1'b1;
         r_rd_n    <= 1'b1;
         r_bus_out <= 8'h00;
         r_bus_oe  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (w_nxt != r_state) r_cnt <= w_load;
         else if (!w_zero)     r_cnt <= r_cnt - 1'b1;
         if (r_state == S_IDLE && start) begin
            r_rw    <= rw;
            r_addr  <= addr;
            r_wdata <= wdata;
         end
         r_busy    <= (w_nxt != S_IDLE) && (w_nxt != S_FIN);
         r_done    <= (w_nxt == S_FIN);
         r_cs_n    <= !(w_a_ph || w_d_ph);
         r_ad      <= w_d_ph;
         r_wr_n    <= !(w_nxt == S_A_STB || (w_nxt == S_D_STB && !r_rw));
         r_rd_n    <= !(w_nxt == S_D_STB && r_rw);
         r_bus_oe  <= w_a_ph || (w_d_ph && !r_rw);
         r_bus_out <= w_a_ph ? w_addr :
                      (w_d_ph && !r_rw) ? r_wdata : 8'h00;
         // sample while rd_n is still low on the final strobe clock
         if (r_state == S_D_STB && w_zero && r_rw) r_rdata <= bus_in;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign rdata   = r_rdata;
   assign cs_n    = r_cs_n;
   assign ad      = r_ad;
   assign wr_n    = r_wr_n;
   assign rd_n    = r_rd_n;
   assign bus_out = r_bus_out;
   assign bus_oe  = r_bus_oe;

endmodule
